// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, BITS_N data bits LSB first, optional parity, one stop bit.
// All outputs are registered; a word waiting when the stop bit ends is taken without an idle gap.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    output logic              baud_trigger
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam bit          PAR_EN  = (PARITY_TYPE == 1) || (PARITY_TYPE == 2);
    localparam bit          PAR_ODD = (PARITY_TYPE == 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [BITS_N-1:0]  shreg, shreg_n;
    logic               par, par_n;
    logic               bit_end;
    logic               uart_out_d;
    logic               ready_d;
    logic               baud_trigger_d;

    assign bit_end = (cnt == CNT_LAST);

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            uart_out     <= 1'b1;
            ready        <= 1'b1;
            baud_trigger <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shreg        <= shreg_n;
            par          <= par_n;
            uart_out     <= uart_out_d;
            ready        <= ready_d;
            baud_trigger <= baud_trigger_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    shreg_n = data_tx;
                    par_n   = (^data_tx) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        state_n = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    // Chain straight into the next start bit so frames abut exactly
                    if (valid) begin
                        state_n = S_START;
                        idx_n   = '0;
                        shreg_n = data_tx;
                        par_n   = (^data_tx) ^ PAR_ODD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        uart_out_d     = 1'b1;
        ready_d        = 1'b0;
        baud_trigger_d = 1'b0;
        case (state_n)
            S_IDLE:   ready_d    = 1'b1;
            S_START:  uart_out_d = 1'b0;
            S_DATA:   uart_out_d = shreg_n[0];
            S_PARITY: uart_out_d = par_n;
            default:  uart_out_d = 1'b1;
        endcase
        if (state_n != S_IDLE && cnt_n == CNT_LAST) begin
            baud_trigger_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 8N1, odd/even parity, back-to-back, mid-frame reset
// and a default-parameter frame, each compared against hand-computed frame images.
module tb_uart_transmitter;

    logic       clk;
    logic [3:0] rst_v;
    logic [3:0] valid_v;
    logic [7:0] data_v [4];
    logic [3:0] uart_v;
    logic [3:0] ready_v;
    logic [3:0] baud_v;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1, 1: odd parity, 2: even parity (all 4 clocks/bit), 3: default parameters
    uart_transmitter #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0)) dut0 (
        .clk(clk), .rst(rst_v[0]), .data_tx(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .uart_out(uart_v[0]), .baud_trigger(baud_v[0]));
    uart_transmitter #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .data_tx(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .uart_out(uart_v[1]), .baud_trigger(baud_v[1]));
    uart_transmitter #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2)) dut2 (
        .clk(clk), .rst(rst_v[2]), .data_tx(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .uart_out(uart_v[2]), .baud_trigger(baud_v[2]));
    uart_transmitter dut3 (
        .clk(clk), .rst(rst_v[3]), .data_tx(data_v[3]), .valid(valid_v[3]),
        .ready(ready_v[3]), .uart_out(uart_v[3]), .baud_trigger(baud_v[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a word for one accept edge; returns at the negedge of frame cycle 0
    task automatic issue(input int k, input logic [7:0] w, input bit hold);
        @(negedge clk);
        data_v[k]  = w;
        valid_v[k] = 1'b1;
        @(negedge clk);
        if (!hold) valid_v[k] = 1'b0;
    endtask

    // Sample one frame of nb bits; returns at the negedge of the cycle after the frame
    task automatic capture(input int k, input int cpb, input int nb,
                           output logic [10:0] frame, output int rdy_low,
                           output int trig, output int bad_trig, output int glitch);
        frame = '0; rdy_low = 0; trig = 0; bad_trig = 0; glitch = 0;
        for (int i = 0; i < nb * cpb; i++) begin
            if (i % cpb == 0) frame[i / cpb] = uart_v[k];
            else if (uart_v[k] !== frame[i / cpb]) glitch++;
            if (ready_v[k] === 1'b0) rdy_low++;
            if (baud_v[k] === 1'b1) begin
                trig++;
                if (i % cpb != cpb - 1) bad_trig++;
            end
            @(negedge clk);
        end
    endtask

    // Full single-frame check: image, ready window, trigger count/placement, idle after
    task automatic frame_test(input string tag, input int k, input int cpb, input int nb,
                              input logic [7:0] w, input logic [10:0] exp_frame);
        logic [10:0] fr;
        int rl, tg, bt, gl;
        issue(k, w, 1'b0);
        capture(k, cpb, nb, fr, rl, tg, bt, gl);
        check({tag, "_frame"},   32'(fr), 32'(exp_frame));
        check({tag, "_rdy_low"}, 32'(rl), 32'(nb * cpb));
        check({tag, "_trig"},    32'(tg), 32'(nb));
        check({tag, "_trig_pos"}, 32'(bt), 32'd0);
        check({tag, "_glitch"},  32'(gl), 32'd0);
        check({tag, "_rdy_after"}, 32'(ready_v[k]), 32'd1);
        check({tag, "_line_after"}, 32'(uart_v[k]), 32'd1);
    endtask

    initial begin
        logic [10:0] fr;
        int rl, tg, bt, gl, bad;
        n_cmp = 0;
        n_err = 0;
        rst_v   = 4'b0000;
        valid_v = 4'b0000;
        for (int j = 0; j < 4; j++) data_v[j] = 8'h00;

        repeat (4) @(negedge clk);
        check("rst_line",  32'(uart_v),  32'hF);
        check("rst_ready", 32'(ready_v), 32'hF);
        check("rst_baud",  32'(baud_v),  32'h0);
        rst_v = 4'b1111;

        // Idle with valid low: line high, ready high, no triggers
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_v !== 4'hF || ready_v !== 4'hF || baud_v !== 4'h0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        frame_test("8n1_7b",   0, 4, 10, 8'h7B, 11'h2F6);
        frame_test("odd_31",   1, 4, 11, 8'h31, 11'h462);
        frame_test("even_31",  2, 4, 11, 8'h31, 11'h662);

        // Back-to-back with data_tx changed during the first frame
        issue(0, 8'h41, 1'b1);
        data_v[0] = 8'h0A;
        capture(0, 4, 10, fr, rl, tg, bt, gl);
        check("b2b_frame1",  32'(fr), 32'h282);
        check("b2b_rdy_low", 32'(rl), 32'd40);
        check("b2b_trig1",   32'(tg), 32'd10);
        check("b2b_glitch1", 32'(gl), 32'd0);
        check("b2b_start2",  32'(uart_v[0]), 32'd0);
        valid_v[0] = 1'b0;
        capture(0, 4, 10, fr, rl, tg, bt, gl);
        check("b2b_frame2",  32'(fr), 32'h214);
        check("b2b_trig2",   32'(tg), 32'd10);
        check("b2b_rdy_after", 32'(ready_v[0]), 32'd1);

        // Asynchronous reset during data bit 3 of an all-zero word
        issue(0, 8'h00, 1'b0);
        repeat (17) @(negedge clk);
        check("mid_pre_line", 32'(uart_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        #1;
        check("mid_rst_line",  32'(uart_v[0]),  32'd1);
        check("mid_rst_ready", 32'(ready_v[0]), 32'd1);
        check("mid_rst_baud",  32'(baud_v[0]),  32'd0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        frame_test("post_rst_55", 0, 4, 10, 8'h55, 11'h2AA);

        frame_test("dflt_7d", 3, 434, 10, 8'h7D, 11'h2FA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
